// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: runs one read or write cycle on the RTC chip's multiplexed
// address/data bus. Each cycle has an address phase and a data phase. Every
// phase has three timed parts: setup (T_SETUP), strobe (T_STROBE) and
// recovery (T_RECOV).
//
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   win, rin                level write/read requests (write has priority)
//   address, dataio         register address / write data, latched at cycle start
//   ad_out, ad_oe, ad_in    A/D pad output value, output enable, pad input
//   cs_n, ad_n, wr_n, rd_n  chip select, address(0)/data(1) select, strobes
//   data_rd                 last captured read data
//   donew, doner            one-cycle completion pulses
//   busy                    high while a cycle is in progress (A_SET..DONE)
//   verr                    write-verify mismatch pulse (0 unless enabled)
//
// Optional feature: define RTC_WRITE_VERIFY_EN to follow every write with an
// internal read-back of the same address. The read-back is compared against
// the written data, and verr is flagged alongside donew on a mismatch.
module rtc_bus_sequencer #(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_STROBE = 4,
    parameter int unsigned T_RECOV  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       win,
    input  logic       rin,
    input  logic [7:0] address,
    input  logic [7:0] dataio,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] data_rd,
    output logic       donew,
    output logic       doner,
    output logic       busy,
    output logic       verr
);

    localparam int unsigned CW = 4;
    localparam int unsigned DW = 8;
    localparam logic [CW-1:0] CNT_SETUP  = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] CNT_STROBE = CW'(T_STROBE - 1);
    localparam logic [CW-1:0] CNT_RECOV  = CW'(T_RECOV - 1);

`ifdef RTC_WRITE_VERIFY_EN
    localparam bit VERIFY_EN = 1'b1;
`else
    localparam bit VERIFY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_SET = 3'd1,
        A_STB = 3'd2,
        A_REC = 3'd3,
        D_SET = 3'd4,
        D_STB = 3'd5,
        D_REC = 3'd6,
        DONE  = 3'd7
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          op_wr, op_wr_nx;     // current pass drives the bus as a write
    logic          vfy, vfy_nx;         // current pass is the internal read-back
    logic [DW-1:0] addr_q, addr_nx;
    logic [DW-1:0] data_q, data_nx;
    logic          vmis;                // read-back differed from written data
    logic          last;

    logic          cs_n_nx, ad_n_nx, wr_n_nx, rd_n_nx, ad_oe_nx;
    logic          donew_nx, doner_nx, busy_nx, verr_nx;
    logic [DW-1:0] ad_out_nx;

    assign last = (cnt == '0);

    // State register and latched cycle context
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_wr  <= 1'b0;
            vfy    <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            op_wr  <= op_wr_nx;
            vfy    <= vfy_nx;
            addr_q <= addr_nx;
            data_q <= data_nx;
        end
    end

    // Next-state: walk the six timed sub-phases, reloading the counter per state
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_wr_nx = op_wr;
        vfy_nx   = vfy;
        addr_nx  = addr_q;
        data_nx  = data_q;
        case (state)
            IDLE: begin
                if (win || rin) begin
                    state_nx = A_SET;
                    cnt_nx   = CNT_SETUP;
                    op_wr_nx = win;
                    vfy_nx   = 1'b0;
                    addr_nx  = address;
                    data_nx  = dataio;
                end
            end
            A_SET: begin
                if (last) begin
                    state_nx = A_STB;
                    cnt_nx   = CNT_STROBE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            A_STB: begin
                if (last) begin
                    state_nx = A_REC;
                    cnt_nx   = CNT_RECOV;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            A_REC: begin
                if (last) begin
                    state_nx = D_SET;
                    cnt_nx   = CNT_SETUP;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            D_SET: begin
                if (last) begin
                    state_nx = D_STB;
                    cnt_nx   = CNT_STROBE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            D_STB: begin
                if (last) begin
                    state_nx = D_REC;
                    cnt_nx   = CNT_RECOV;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            D_REC: begin
                if (last) begin
                    if (VERIFY_EN && op_wr) begin
                        // Second pass: read the same address back
                        state_nx = A_SET;
                        cnt_nx   = CNT_SETUP;
                        op_wr_nx = 1'b0;
                        vfy_nx   = 1'b1;
                    end else begin
                        state_nx = DONE;
                    end
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered pins line up with it
    always_comb begin
        cs_n_nx   = 1'b1;
        ad_n_nx   = 1'b1;
        wr_n_nx   = 1'b1;
        rd_n_nx   = 1'b1;
        ad_oe_nx  = 1'b0;
        ad_out_nx = ad_out;
        donew_nx  = 1'b0;
        doner_nx  = 1'b0;
        verr_nx   = 1'b0;
        busy_nx   = (state_nx != IDLE);
        case (state_nx)
            A_SET, A_STB: begin
                cs_n_nx   = 1'b0;
                ad_n_nx   = 1'b0;
                ad_oe_nx  = 1'b1;
                ad_out_nx = addr_nx;
                wr_n_nx   = (state_nx == A_STB) ? 1'b0 : 1'b1;
            end
            D_SET, D_STB: begin
                cs_n_nx = 1'b0;
                if (op_wr_nx) begin
                    ad_oe_nx  = 1'b1;
                    ad_out_nx = data_nx;
                    wr_n_nx   = (state_nx == D_STB) ? 1'b0 : 1'b1;
                end else begin
                    rd_n_nx = (state_nx == D_STB) ? 1'b0 : 1'b1;
                end
            end
            DONE: begin
                donew_nx = op_wr_nx || vfy_nx;
                doner_nx = !(op_wr_nx || vfy_nx);
                verr_nx  = VERIFY_EN && vfy_nx && vmis;
            end
            default: ;
        endcase
    end

    // Registered pins
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cs_n   <= 1'b1;
            ad_n   <= 1'b1;
            wr_n   <= 1'b1;
            rd_n   <= 1'b1;
            ad_oe  <= 1'b0;
            ad_out <= '0;
            donew  <= 1'b0;
            doner  <= 1'b0;
            busy   <= 1'b0;
            verr   <= 1'b0;
        end else begin
            cs_n   <= cs_n_nx;
            ad_n   <= ad_n_nx;
            wr_n   <= wr_n_nx;
            rd_n   <= rd_n_nx;
            ad_oe  <= ad_oe_nx;
            ad_out <= ad_out_nx;
            donew  <= donew_nx;
            doner  <= doner_nx;
            busy   <= busy_nx;
            verr   <= verr_nx;
        end
    end

    // Read capture on the final strobe cycle; the read-back only feeds the compare
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_rd <= '0;
            vmis    <= 1'b0;
        end else if (state == D_STB && last && !op_wr) begin
            if (vfy) begin
                vmis <= (ad_in != data_q);
            end else begin
                data_rd <= ad_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer. Expected pin values are derived
// per cycle from the phase timing (setup/strobe/recovery arithmetic). They are
// not derived from the design's state machine.
module tb_rtc_bus_sequencer;

    localparam int S = 2;
    localparam int B = 4;
    localparam int R = 3;
    localparam int P = S + B + R;
`ifdef RTC_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic       clk, rst_n, win, rin;
    logic [7:0] address, dataio, ad_in;
    logic [7:0] ad_out, data_rd;
    logic       ad_oe, cs_n, ad_n, wr_n, rd_n, donew, doner, busy, verr;

    int         vec;
    int         errs;
    logic [7:0] exp_rd;

    rtc_bus_sequencer #(.T_SETUP(S), .T_STROBE(B), .T_RECOV(R)) dut (
        .clock   (clk),
        .reset   (rst_n),
        .win     (win),
        .rin     (rin),
        .address (address),
        .dataio  (dataio),
        .ad_out  (ad_out),
        .ad_oe   (ad_oe),
        .ad_in   (ad_in),
        .cs_n    (cs_n),
        .ad_n    (ad_n),
        .wr_n    (wr_n),
        .rd_n    (rd_n),
        .data_rd (data_rd),
        .donew   (donew),
        .doner   (doner),
        .busy    (busy),
        .verr    (verr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction. The caller has already raised the request, and the next
    // posedge leaves IDLE. Cycle k = 1 is the first cycle after that edge.
    task automatic run_txn(input bit is_wr, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] pad, input int drop_k, input int abort_k,
                           input bit nwin, input bit nrin,
                           input logic [7:0] na, input logic [7:0] nd);
        int n;
        int pass, o;
        bit done, st, rc, pass_wr, addr_ph;
        logic [8:0] e_ctl, a_ctl;
        logic [7:0] e_out;
        n = ((is_wr && VFY) ? 4 : 2) * P + 1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (k < n) begin
                address = 8'($urandom);
                dataio  = 8'($urandom);
            end
            pass    = (k - 1) / P;
            o       = (k - 1) % P;
            done    = (k == n);
            st      = !done && o >= S && o < S + B;
            rc      = !done && o >= S + B;
            pass_wr = is_wr && pass < 2;
            addr_ph = (pass % 2) == 0;
            ad_in   = (!done && !addr_ph && st && !pass_wr) ? pad : 8'($urandom);
            if (!is_wr && k == P + S + B + 1) exp_rd = pad;
            @(negedge clk);
            e_ctl[8] = done ? 1'b1 : rc;
            e_ctl[7] = (done || !addr_ph) ? 1'b1 : rc;
            e_ctl[6] = !(st && (addr_ph || pass_wr));
            e_ctl[5] = !(st && !addr_ph && !pass_wr);
            e_ctl[4] = !done && !rc && (addr_ph || pass_wr);
            e_ctl[3] = 1'b1;
            e_ctl[2] = done && is_wr;
            e_ctl[1] = done && !is_wr;
            e_ctl[0] = done && is_wr && VFY && (pad != d);
            a_ctl = {cs_n, ad_n, wr_n, rd_n, ad_oe, busy, donew, doner, verr};
            vec++;
            if (a_ctl !== e_ctl) begin
                errs++;
                $display("FAIL ctl k=%0d got cs,adn,wr,rd,oe,busy,dw,dr,verr=%b want %b", k, a_ctl, e_ctl);
            end
            if (e_ctl[4]) begin
                e_out = addr_ph ? a : d;
                vec++;
                if (ad_out !== e_out) begin
                    errs++;
                    $display("FAIL ad_out k=%0d got %h want %h", k, ad_out, e_out);
                end
            end
            vec++;
            if (data_rd !== exp_rd) begin
                errs++;
                $display("FAIL data_rd k=%0d got %h want %h", k, data_rd, exp_rd);
            end
            if (k == drop_k) begin
                if (is_wr) win = 1'b0;
                else rin = 1'b0;
            end
            if (k == abort_k) begin
                #2 rst_n = 1'b0;
                #1;
                exp_rd = 8'h00;
                vec++;
                if ({cs_n, wr_n, rd_n, ad_oe, busy, donew} !== 6'b111000) begin
                    errs++;
                    $display("FAIL async_reset got cs,wr,rd,oe,busy,dw=%b want 111000",
                             {cs_n, wr_n, rd_n, ad_oe, busy, donew});
                end
                break;
            end
            if (done) begin
                win     = nwin;
                rin     = nrin;
                address = na;
                dataio  = nd;
            end
        end
    endtask

    // The cycle right after DONE must be IDLE
    task automatic check_idle(input string tag);
        @(negedge clk);
        vec++;
        if ({busy, cs_n, donew, doner} !== 4'b0100) begin
            errs++;
            $display("FAIL %s idle got busy,cs,dw,dr=%b want 0100", tag, {busy, cs_n, donew, doner});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; win = 1'b0; rin = 1'b0;
        address = 8'h00; dataio = 8'h00; ad_in = 8'h00;
        exp_rd = 8'h00;
        #12;
        vec++;
        if ({cs_n, wr_n, rd_n, ad_n, ad_oe, donew, doner, busy, verr} !== 9'b111100000) begin
            errs++;
            $display("FAIL reset_ctl got %b want 111100000",
                     {cs_n, wr_n, rd_n, ad_n, ad_oe, donew, doner, busy, verr});
        end
        vec++;
        if ({ad_out, data_rd} !== 16'h0000) begin
            errs++;
            $display("FAIL reset_data got %h want 0000", {ad_out, data_rd});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        win = 1'b1; address = 8'h21; dataio = 8'h45;
        run_txn(1'b1, 8'h21, 8'h45, 8'h45, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        check_idle("write");
    endtask

    task automatic test_read();
        rin = 1'b1; address = 8'h26;
        run_txn(1'b0, 8'h26, 8'h00, 8'h16, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        check_idle("read");
        vec++;
        if (data_rd !== 8'h16) begin
            errs++;
            $display("FAIL read_hold got %h want 16", data_rd);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        win = 1'b1; rin = 1'b1; address = 8'h11; dataio = 8'hA5;
        run_txn(1'b1, 8'h11, 8'hA5, 8'hA5, 0, 0, 1'b0, 1'b1, 8'h12, 8'h00);
        check_idle("priority");
        run_txn(1'b0, 8'h12, 8'h00, 8'h5C, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        check_idle("priority_rd");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        win = 1'b1; address = 8'h33; dataio = 8'h77;
        run_txn(1'b1, 8'h33, 8'h77, 8'h77, 0, P + S + 1, 1'b0, 1'b0, 8'h00, 8'h00);
        win = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * P + 4; i++) begin
            @(negedge clk);
            vec++;
            if ({donew, busy} !== 2'b00) begin
                errs++;
                $display("FAIL post_reset i=%0d got dw,busy=%b want 00", i, {donew, busy});
            end
        end
        win = 1'b1; address = 8'h34; dataio = 8'h78;
        run_txn(1'b1, 8'h34, 8'h78, 8'h78, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        check_idle("reset_mid");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        win = 1'b1; address = 8'h26; dataio = 8'h9E;
        run_txn(1'b1, 8'h26, 8'h9E, 8'h9E, 0, 0, 1'b1, 1'b0, 8'h25, 8'h3C);
        check_idle("b2b");
        run_txn(1'b1, 8'h25, 8'h3C, 8'h3C, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        check_idle("b2b_2");
    endtask

    task automatic test_random();
        bit         w;
        logic [7:0] a, d, pad;
        int         dk;
        for (int t = 0; t < 10; t++) begin
            w   = 1'($urandom);
            a   = 8'($urandom);
            d   = 8'($urandom);
            pad = (VFY && w && $urandom_range(0, 1) == 0) ? d : 8'($urandom);
            dk  = $urandom_range(0, 2 * P);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            win = w; rin = !w || 1'($urandom); address = a; dataio = d;
            run_txn(w, a, d, pad, dk, 0, 1'b0, 1'b0, 8'h00, 8'h00);
            check_idle("random");
        end
    endtask

`ifdef RTC_WRITE_VERIFY_EN
    task automatic test_write_verify();
        @(negedge clk);
        win = 1'b1; address = 8'h40; dataio = 8'h30;
        run_txn(1'b1, 8'h40, 8'h30, 8'h31, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        check_idle("verify_bad");
        @(negedge clk);
        win = 1'b1; address = 8'h40; dataio = 8'h30;
        run_txn(1'b1, 8'h40, 8'h30, 8'h30, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        check_idle("verify_ok");
    endtask
`endif

    initial begin
        vec  = 0;
        errs = 0;
        test_reset();
        test_write();
        test_read();
        test_priority();
        test_reset_mid();
        test_back_to_back();
`ifdef RTC_WRITE_VERIFY_EN
        test_write_verify();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
